// File: rtl/prog_mem_server_if.sv
// Load and fetch bus of prog_mem_server. The host and controller side use the master modport.
// Under PROG_MEM_PARITY_EN the bus also carries the par_err pulse.
interface prog_mem_server_if #(
  parameter int unsigned INSTR_W = 31,
  parameter int unsigned ADDR_W  = 5
);
  logic               prog;
  logic               ld_valid;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_last;
  logic               ld_ready;
  logic               fetch;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr_word;
  logic               instr_valid;
  logic               err_oob;
  logic               loaded;
  logic [ADDR_W:0]    prog_len;
`ifdef PROG_MEM_PARITY_EN
  logic               par_err;

  modport master (
    output prog, ld_valid, ld_data, ld_last, fetch, pc,
    input  ld_ready, instr_word, instr_valid, err_oob, loaded, prog_len, par_err
  );
  modport slave (
    input  prog, ld_valid, ld_data, ld_last, fetch, pc,
    output ld_ready, instr_word, instr_valid, err_oob, loaded, prog_len, par_err
  );
`else
  modport master (
    output prog, ld_valid, ld_data, ld_last, fetch, pc,
    input  ld_ready, instr_word, instr_valid, err_oob, loaded, prog_len
  );
  modport slave (
    input  prog, ld_valid, ld_data, ld_last, fetch, pc,
    output ld_ready, instr_word, instr_valid, err_oob, loaded, prog_len
  );
`endif
endinterface

// File: rtl/prog_mem_server.sv
// Program memory: loads the program over a valid/ready port while prog is high, then answers fetches with latency 1.
// Optional macro PROG_MEM_PARITY_EN adds an even-parity bit per stored word and the par_err pulse.
module prog_mem_server #(
  parameter int unsigned INSTR_W   = 31,
  parameter int unsigned PROG_SIZE = 32,
  parameter int unsigned ADDR_W    = $clog2(PROG_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  prog_mem_server_if.slave  bus
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

`ifdef PROG_MEM_PARITY_EN
  localparam int unsigned MEM_W = INSTR_W + 1;
`else
  localparam int unsigned MEM_W = INSTR_W;
`endif

  logic [MEM_W-1:0]   r_mem [PROG_SIZE];
  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W:0]    r_prog_len;
  logic [INSTR_W-1:0] r_instr_word;
  logic               r_instr_valid;
  logic               r_err_oob;

  logic               w_ld_ready;
  logic               w_accept;
  logic               w_at_end;
  logic               w_term;
  logic               w_hit;
  logic [MEM_W-1:0]   w_rd;
  logic [MEM_W-1:0]   w_wr_word;
  logic               w_par_ok;

  // Dropping prog closes the port in that very cycle, so an abort never accepts a beat.
  assign w_ld_ready = (r_state == S_LOAD) && bus.prog;
  assign w_accept   = w_ld_ready && bus.ld_valid;
  assign w_at_end   = (r_wr_ptr == ADDR_W'(PROG_SIZE - 1));
  assign w_term     = w_accept && (bus.ld_last || w_at_end);
  assign w_hit      = ({1'b0, bus.pc} < r_prog_len);
  assign w_rd       = r_mem[bus.pc];

`ifdef PROG_MEM_PARITY_EN
  logic r_par_err;
  assign w_wr_word   = {^bus.ld_data, bus.ld_data};
  assign w_par_ok    = ~(^w_rd);
  assign bus.par_err = r_par_err;
`else
  assign w_wr_word = bus.ld_data;
  assign w_par_ok  = 1'b1;
`endif

  assign bus.ld_ready    = w_ld_ready;
  assign bus.loaded      = (r_state == S_READY);
  assign bus.prog_len    = r_prog_len;
  assign bus.instr_word  = r_instr_word;
  assign bus.instr_valid = r_instr_valid;
  assign bus.err_oob     = r_err_oob;

  // No reset on the array: contents survive reset but stay unreachable until a new load.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_EMPTY;
      r_wr_ptr      <= '0;
      r_prog_len    <= '0;
      r_instr_word  <= '0;
      r_instr_valid <= 1'b0;
      r_err_oob     <= 1'b0;
`ifdef PROG_MEM_PARITY_EN
      r_par_err     <= 1'b0;
`endif
    end else begin
      r_instr_valid <= 1'b0;
      r_err_oob     <= 1'b0;
`ifdef PROG_MEM_PARITY_EN
      r_par_err     <= 1'b0;
`endif
      case (r_state)
        S_EMPTY: begin
          if (bus.prog) begin
            r_state  <= S_LOAD;
            r_wr_ptr <= '0;
          end
        end
        S_LOAD: begin
          if (!bus.prog) begin
            if (r_wr_ptr == '0) begin
              r_state    <= S_EMPTY;
              r_prog_len <= '0;
            end else begin
              r_state    <= S_READY;
              r_prog_len <= {1'b0, r_wr_ptr};
            end
          end else if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_term) begin
              r_state    <= S_READY;
              r_prog_len <= {1'b0, r_wr_ptr} + (ADDR_W + 1)'(1);
            end
          end
        end
        S_READY: begin
          if (bus.prog) begin
            r_state  <= S_LOAD;
            r_wr_ptr <= '0;
          end else if (bus.fetch) begin
            if (!w_hit) begin
              r_instr_word <= '0;
              r_err_oob    <= 1'b1;
            end else if (!w_par_ok) begin
              r_instr_word <= '0;
`ifdef PROG_MEM_PARITY_EN
              r_par_err    <= 1'b1;
`endif
            end else begin
              r_instr_word  <= w_rd[INSTR_W-1:0];
              r_instr_valid <= 1'b1;
            end
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem_server.sv
// Directed self-checking bench for prog_mem_server: reset, loads, fetches, out-of-range, abort and reload.
module tb_prog_mem_server;

  localparam int unsigned INSTR_W   = 31;
  localparam int unsigned PROG_SIZE = 32;
  localparam int unsigned ADDR_W    = 5;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  prog_mem_server_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W)) bus ();

  prog_mem_server #(.INSTR_W(INSTR_W), .PROG_SIZE(PROG_SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++; if (bus.instr_word !== 31'h0) begin failures++; $display("FAIL rst_word got=%h exp=0", bus.instr_word); end
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.err_oob !== 1'b0) begin failures++; $display("FAIL rst_oob got=%b exp=0", bus.err_oob); end
    checks++; if (bus.loaded !== 1'b0) begin failures++; $display("FAIL rst_loaded got=%b exp=0", bus.loaded); end
    checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL rst_ld_ready got=%b exp=0", bus.ld_ready); end
    checks++; if (bus.prog_len !== 6'd0) begin failures++; $display("FAIL rst_prog_len got=%0d exp=0", bus.prog_len); end
    step();
    step();
    rst = 1'b0;
    bus.fetch = 1'b1;
    bus.pc    = 5'd0;
    step();
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL empty_fetch_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.err_oob !== 1'b0) begin failures++; $display("FAIL empty_fetch_oob got=%b exp=0", bus.err_oob); end
    bus.fetch = 1'b0;
  endtask

  task automatic test_short_load();
    bus.prog = 1'b1;
    step();
    checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL load_ld_ready got=%b exp=1", bus.ld_ready); end
    bus.ld_valid = 1'b1;
    bus.ld_data  = 31'h0123_4567; step();
    bus.ld_data  = 31'h0ABC_DEF0; step();
    bus.ld_data  = 31'h7FFF_FFFF; bus.ld_last = 1'b1; step();
    bus.prog = 1'b0; bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    #1;
    checks++; if (bus.loaded !== 1'b1) begin failures++; $display("FAIL short_loaded got=%b exp=1", bus.loaded); end
    checks++; if (bus.prog_len !== 6'd3) begin failures++; $display("FAIL short_prog_len got=%0d exp=3", bus.prog_len); end
    checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL short_ld_ready got=%b exp=0", bus.ld_ready); end
    bus.fetch = 1'b1; bus.pc = 5'd1;
    step();
    checks++; if (bus.instr_word !== 31'h0ABC_DEF0) begin failures++; $display("FAIL fetch1_word got=%h exp=0abcdef0", bus.instr_word); end
    checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL fetch1_valid got=%b exp=1", bus.instr_valid); end
    bus.fetch = 1'b0;
    step();
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.instr_word !== 31'h0ABC_DEF0) begin failures++; $display("FAIL idle_word_hold got=%h exp=0abcdef0", bus.instr_word); end
  endtask

  task automatic test_out_of_range();
    bus.fetch = 1'b1; bus.pc = 5'd5;
    step();
    checks++; if (bus.instr_word !== 31'h0) begin failures++; $display("FAIL oob_word got=%h exp=0", bus.instr_word); end
    checks++; if (bus.err_oob !== 1'b1) begin failures++; $display("FAIL oob_pulse got=%b exp=1", bus.err_oob); end
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL oob_valid got=%b exp=0", bus.instr_valid); end
    bus.fetch = 1'b0;
    step();
    checks++; if (bus.err_oob !== 1'b0) begin failures++; $display("FAIL oob_one_cycle got=%b exp=0", bus.err_oob); end
    bus.fetch = 1'b1; bus.pc = 5'd2;
    step();
    checks++; if (bus.instr_word !== 31'h7FFF_FFFF) begin failures++; $display("FAIL fetch2_word got=%h exp=7fffffff", bus.instr_word); end
    checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL fetch2_valid got=%b exp=1", bus.instr_valid); end
    bus.fetch = 1'b0;
    step();
  endtask

  task automatic test_full_load();
    int pulses;
    bus.prog = 1'b1;
    step();
    checks++; if (bus.loaded !== 1'b0) begin failures++; $display("FAIL reload_loaded got=%b exp=0", bus.loaded); end
    for (int i = 0; i < 32; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 31'(i * 3);
      step();
    end
    checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL full_ld_ready got=%b exp=0", bus.ld_ready); end
    bus.prog = 1'b0; bus.ld_valid = 1'b0;
    #1;
    checks++; if (bus.prog_len !== 6'd32) begin failures++; $display("FAIL full_prog_len got=%0d exp=32", bus.prog_len); end
    checks++; if (bus.loaded !== 1'b1) begin failures++; $display("FAIL full_loaded got=%b exp=1", bus.loaded); end
    bus.fetch = 1'b1; bus.pc = 5'd31;
    step();
    checks++; if (bus.instr_word !== 31'd93) begin failures++; $display("FAIL full_pc31 got=%0d exp=93", bus.instr_word); end
    pulses = 0;
    for (int p = 0; p < 32; p++) begin
      bus.pc = 5'(p);
      step();
      if (bus.instr_valid === 1'b1) pulses++;
      checks++; if (bus.instr_word !== 31'(p * 3)) begin failures++; $display("FAIL sweep_word pc=%0d got=%0d exp=%0d", p, bus.instr_word, p * 3); end
    end
    checks++; if (pulses !== 32) begin failures++; $display("FAIL sweep_pulses got=%0d exp=32", pulses); end
    bus.fetch = 1'b0;
    step();
  endtask

  task automatic test_abort_backpressure();
    bus.prog = 1'b1; bus.ld_valid = 1'b0;
    step();
    bus.ld_valid = 1'b1; bus.ld_data = 31'h111; step();
    bus.ld_valid = 1'b0; step();
    bus.ld_valid = 1'b1; bus.ld_data = 31'h222; step();
    bus.ld_valid = 1'b0; step();
    bus.prog = 1'b0; bus.ld_valid = 1'b1; bus.ld_data = 31'h333;
    #1;
    checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL abort_ld_ready got=%b exp=0", bus.ld_ready); end
    step();
    bus.ld_valid = 1'b0;
    checks++; if (bus.loaded !== 1'b1) begin failures++; $display("FAIL abort_loaded got=%b exp=1", bus.loaded); end
    checks++; if (bus.prog_len !== 6'd2) begin failures++; $display("FAIL abort_prog_len got=%0d exp=2", bus.prog_len); end
    bus.fetch = 1'b1; bus.pc = 5'd2;
    step();
    checks++; if (bus.err_oob !== 1'b1) begin failures++; $display("FAIL abort_oob got=%b exp=1", bus.err_oob); end
    bus.pc = 5'd1;
    step();
    checks++; if (bus.instr_word !== 31'h222) begin failures++; $display("FAIL abort_word got=%h exp=222", bus.instr_word); end
    bus.prog = 1'b1; bus.pc = 5'd0;
    step();
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL prog_fetch_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.err_oob !== 1'b0) begin failures++; $display("FAIL prog_fetch_oob got=%b exp=0", bus.err_oob); end
    checks++; if (bus.loaded !== 1'b0) begin failures++; $display("FAIL prog_fetch_loaded got=%b exp=0", bus.loaded); end
    checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL prog_fetch_ld_ready got=%b exp=1", bus.ld_ready); end
    checks++; if (bus.instr_word !== 31'h222) begin failures++; $display("FAIL prog_fetch_word got=%h exp=222", bus.instr_word); end
    bus.fetch = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    for (int i = 0; i < 4; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 31'(16'hA000 + i);
      step();
    end
    bus.ld_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.loaded !== 1'b0) begin failures++; $display("FAIL midrst_loaded got=%b exp=0", bus.loaded); end
    checks++; if (bus.prog_len !== 6'd0) begin failures++; $display("FAIL midrst_prog_len got=%0d exp=0", bus.prog_len); end
    checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL midrst_ld_ready got=%b exp=0", bus.ld_ready); end
    checks++; if (bus.instr_word !== 31'h0) begin failures++; $display("FAIL midrst_word got=%h exp=0", bus.instr_word); end
    bus.prog = 1'b0;
    step();
    rst = 1'b0;
    step();
    bus.fetch = 1'b1; bus.pc = 5'd0;
    step();
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL midrst_fetch_valid got=%b exp=0", bus.instr_valid); end
    checks++; if (bus.loaded !== 1'b0) begin failures++; $display("FAIL midrst_fetch_loaded got=%b exp=0", bus.loaded); end
    bus.fetch = 1'b0;
    step();
  endtask

`ifdef PROG_MEM_PARITY_EN
  task automatic test_parity();
    bus.prog = 1'b1;
    step();
    bus.ld_valid = 1'b1; bus.ld_data = 31'h55; bus.ld_last = 1'b1;
    step();
    bus.prog = 1'b0; bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    dut.r_mem[0][3] = ~dut.r_mem[0][3];
    bus.fetch = 1'b1; bus.pc = 5'd0;
    step();
    checks++; if (bus.par_err !== 1'b1) begin failures++; $display("FAIL par_err got=%b exp=1", bus.par_err); end
    checks++; if (bus.instr_word !== 31'h0) begin failures++; $display("FAIL par_word got=%h exp=0", bus.instr_word); end
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL par_valid got=%b exp=0", bus.instr_valid); end
    bus.fetch = 1'b0;
    step();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst          = 1'b1;
    bus.prog     = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.fetch    = 1'b0;
    bus.pc       = '0;
    test_reset();
    test_short_load();
    test_out_of_range();
    test_full_load();
    test_abort_backpressure();
    test_reset_mid_load();
`ifdef PROG_MEM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_mem_server.md
Name: prog_mem_server

Overview:
- Program-memory responder on the controller's instruction fetch interface.
- Loads the filter program through a valid/ready load port while the controller is held in prog mode.
- Answers each controller fetch (fetch, pc) with the stored instruction word, one clock later.
- Replaces the bench-side ROM array in system builds; sits between the host loader and the controller top.

Parameters:
- INSTR_W, 31, instruction word width (1+1+VEC_ID_W+2*REGFILE_ADDR_W+3*DATA_ADDR_W with defaults 3/4/6).
- PROG_SIZE, 32, program memory depth in words.
- ADDR_W, $clog2(PROG_SIZE), width of pc and of the write pointer.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- prog  input  1  load-mode request, level.
- ld_valid  input  1  load beat valid.
- ld_data  input  INSTR_W  load beat instruction word.
- ld_last  input  1  final beat of program.
- ld_ready  output  1  load beat accepted when ld_valid && ld_ready.
- fetch  input  1  controller fetch request.
- pc  input  ADDR_W  fetch address.
- instr_word  output  INSTR_W  fetched instruction, registered.
- instr_valid  output  1  one-cycle pulse, instr_word updated this cycle.
- err_oob  output  1  one-cycle pulse, fetch address >= prog_len.
- loaded  output  1  a program is resident and fetchable.
- prog_len  output  ADDR_W+1  number of valid program words (0..PROG_SIZE).

Behaviour:
- Reset (async, immediate):
  - state=EMPTY, wr_ptr=0, prog_len=0.
  - instr_word=0, instr_valid=0, err_oob=0, loaded=0, ld_ready=0.
  - Memory contents are not cleared.
- State machine (EMPTY, LOAD, READY):
  - EMPTY: ld_ready=0, fetch ignored (no pulses, instr_word held). prog=1 -> LOAD, wr_ptr<=0.
  - LOAD: ld_ready=1, loaded=0.
    - Accepted beat: mem[wr_ptr]<=ld_data, wr_ptr<=wr_ptr+1.
    - Accepted beat with ld_last=1, or with wr_ptr==PROG_SIZE-1: -> READY, prog_len<=wr_ptr+1 (ADDR_W+1 bit add, no wrap).
    - prog falls before a terminating beat (abort): wr_ptr==0 -> EMPTY with prog_len=0; otherwise -> READY with prog_len=wr_ptr. A beat presented in the abort cycle is not accepted; ld_ready=0 in that cycle.
    - Fetch ignored in LOAD.
  - READY: loaded=1, ld_ready=0.
    - fetch=1, pc<prog_len: next edge instr_word<=mem[pc], instr_valid=1 for one cycle.
    - fetch=1, pc>=prog_len: next edge instr_word<=0, err_oob=1 for one cycle, instr_valid=0.
    - fetch=0: instr_word held, pulses 0.
    - prog=1 -> LOAD (reload), wr_ptr<=0, loaded falls the next cycle.
- Simultaneous events:
  - prog and fetch in READY: prog wins, fetch dropped, no pulse.
  - Back-to-back fetches: one response per cycle, fully pipelined, latency 1.
- Read-during-write cannot occur, because fetch is ignored in LOAD.
- Reset mid-load: immediate return to EMPTY, prog_len=0; a partially written program is not fetchable.

Optional Feature:
- Macro PROG_MEM_PARITY_EN.
- Defined:
  - Each word is stored with an even-parity bit computed on write.
  - A fetch hit recomputes parity; on mismatch instr_word<=0, instr_valid=0, and output port par_err (1 bit) pulses one cycle.
  - par_err resets to 0.
- Undefined: no parity storage, no par_err port, behaviour exactly as above.

Test Plan:
- Reset: rst=1 while idle and mid-traffic -> all outputs 0 asynchronously, ld_ready=0; fetch pc=0 after release -> no instr_valid.
- Short load: prog=1, beats 31'h0123_4567, 31'h0ABC_DEF0, 31'h7FFF_FFFF, ld_last on beat 3 -> loaded=1, prog_len=3. Then fetch pc=1 -> next cycle instr_word=31'h0ABC_DEF0, instr_valid=1.
- Out of range: prog_len=3, fetch pc=5 -> next cycle instr_word=0, err_oob=1 for exactly one cycle. Then fetch pc=2 -> 31'h7FFF_FFFF.
- Full load: 32 beats (word i = i*3), no ld_last -> after beat 32 ld_ready=0, prog_len=32. Fetch pc=31 -> 93. Fetch sweep pc=0..31 back-to-back -> 32 consecutive instr_valid pulses.
- Abort and backpressure: ld_valid toggled every other cycle, prog dropped after 2 accepted beats -> READY, prog_len=2. prog+fetch same cycle in READY -> LOAD, no response pulse.
- Reset mid-load after 4 beats -> loaded=0, prog_len=0, EMPTY. Under PROG_MEM_PARITY_EN, flip a stored bit hierarchically, fetch it -> par_err=1, instr_word=0.
